// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: per-stage hold enables, flush/redirect sequencing, stall statistics.
// Optional watchdog built when STALL_TIMEOUT_EN is defined; otherwise stall_timeout is tied to 0.
module pipe_ctrl #(
    parameter int unsigned ADDR_W        = 32,
    parameter int unsigned CNT_W         = 16,
    parameter int unsigned STALL_TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic              flush_req,
    input  logic [ADDR_W-1:0] flush_pc,
    output logic [5:0]        stall,
    output logic              flush,
    output logic [ADDR_W-1:0] new_pc,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic              stall_timeout
);

    typedef enum logic [1:0] {
        IDLE,
        STALL,
        FLUSH
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] new_pc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              stall_any;

    if (STALL_TIMEOUT < 2) begin : g_bad_timeout
        $error("pipe_ctrl: STALL_TIMEOUT must be >= 2");
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // stall is gated by rst so the hold enables drop asynchronously with reset
    always_comb begin
        stall   = '0;
        state_d = state_q;
        if (state_q == FLUSH) begin
            state_d = flush_req ? FLUSH : IDLE;
        end else begin
            if (stallreq_mem) begin
                stall = 6'b011111;
            end else if (stallreq_ex) begin
                stall = 6'b001111;
            end else if (stallreq_id) begin
                stall = 6'b000111;
            end
            if (flush_req) begin
                state_d = FLUSH;
            end else if (stallreq_mem || stallreq_ex || stallreq_id) begin
                state_d = STALL;
            end else begin
                state_d = IDLE;
            end
        end
        if (rst) begin
            stall = '0;
        end
    end

    assign stall_any = |stall;
    assign flush     = (state_q == FLUSH);
    assign new_pc    = new_pc_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            new_pc_q <= '0;
        end else if (flush_req) begin
            new_pc_q <= flush_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (stall_any && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign stall_cycles = cnt_q;

`ifdef STALL_TIMEOUT_EN
    localparam int unsigned RUN_W = $clog2(STALL_TIMEOUT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STALL_TIMEOUT);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STALL_TIMEOUT - 1);

    logic [RUN_W-1:0] run_q;
    logic             timeout_q;
    logic             timeout_hit;

    // run_q holds the number of earlier consecutive stall cycles, so the flag
    // shows up during the cycle that completes the run
    assign timeout_hit = stall_any && (run_q == RUN_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            if (!stall_any) begin
                run_q <= '0;
            end else if (run_q != RUN_MAX) begin
                run_q <= run_q + 1'b1;
            end
            if (timeout_hit) begin
                timeout_q <= 1'b1;
            end
        end
    end

    assign stall_timeout = timeout_q | (timeout_hit & ~rst);
`else
    assign stall_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Table-driven self-checking bench for pipe_ctrl (CNT_W=4, STALL_TIMEOUT=8).
// Watchdog checks follow STALL_TIMEOUT_EN as seen by this compilation.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_id, stallreq_ex, stallreq_mem;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [3:0]  stall_cycles;
    logic        stall_timeout;

`ifdef STALL_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    pipe_ctrl #(
        .ADDR_W(32),
        .CNT_W(4),
        .STALL_TIMEOUT(8)
    ) u_dut (
        .clk(clk),
        .rst(rst),
        .stallreq_id(stallreq_id),
        .stallreq_ex(stallreq_ex),
        .stallreq_mem(stallreq_mem),
        .flush_req(flush_req),
        .flush_pc(flush_pc),
        .stall(stall),
        .flush(flush),
        .new_pc(new_pc),
        .stall_cycles(stall_cycles),
        .stall_timeout(stall_timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        id;
        logic        ex;
        logic        mem;
        logic        fr;
        logic [31:0] pc;
        logic [5:0]  stall;
        logic        flush;
        logic [31:0] npc;
    } vec_t;

    localparam int NV = 18;
    vec_t tbl[NV];
    int   nvec = 0;
    int   nerr = 0;
    int   sc_model = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        //             id    ex    mem   fr    pc            stall      flush npc
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        6'b000000, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0,        6'b011111, 1'b0, 32'h0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        6'b000111, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        6'b000000, 1'b0, 32'h0};
        tbl[4]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h40,       6'b001111, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        6'b000000, 1'b1, 32'h40};
        tbl[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        6'b000000, 1'b0, 32'h0};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h100,      6'b000000, 1'b0, 32'h0};
        tbl[8]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h200,      6'b000000, 1'b1, 32'h100};
        tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 32'h300,      6'b000000, 1'b1, 32'h200};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        6'b000000, 1'b1, 32'h300};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        6'b000000, 1'b0, 32'h0};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b0, 32'h0,        6'b011111, 1'b0, 32'h0};
        tbl[13] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        6'b001111, 1'b0, 32'h0};
        tbl[14] = '{1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEC, 6'b011111, 1'b0, 32'h0};
        tbl[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        6'b000000, 1'b1, 32'hDEADBEEC};
        tbl[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        6'b000111, 1'b0, 32'h0};
        tbl[17] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        6'b000000, 1'b0, 32'h0};

        rst = 1'b0;
        stallreq_id = 1'b0; stallreq_ex = 1'b0; stallreq_mem = 1'b0;
        flush_req = 1'b0; flush_pc = '0;
        #2 rst = 1'b1;
        #1;
        chk("rst_stall", 32'(stall), 32'h0);
        chk("rst_flush", 32'(flush), 32'h0);
        chk("rst_new_pc", new_pc, 32'h0);
        chk("rst_cycles", 32'(stall_cycles), 32'h0);
        chk("rst_timeout", 32'(stall_timeout), 32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            chk("idle_stall", 32'(stall), 32'h0);
            chk("idle_flush", 32'(flush), 32'h0);
            chk("idle_cycles", 32'(stall_cycles), 32'h0);
        end

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            stallreq_id = tbl[i].id;
            stallreq_ex = tbl[i].ex;
            stallreq_mem = tbl[i].mem;
            flush_req = tbl[i].fr;
            flush_pc = tbl[i].pc;
            #1;
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'(tbl[i].stall));
            chk($sformatf("v%0d_flush", i), 32'(flush), 32'(tbl[i].flush));
            if (tbl[i].flush)
                chk($sformatf("v%0d_new_pc", i), new_pc, tbl[i].npc);
            chk($sformatf("v%0d_cycles", i), 32'(stall_cycles), 32'(sc_model > 15 ? 15 : sc_model));
            if (tbl[i].stall != 6'b0) sc_model++;
        end

        // 7 stalled cycles so far; 20 more must saturate at 4'hF without wrapping
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            stallreq_ex = 1'b1;
            #1;
            chk("sat_stall", 32'(stall), 32'h0F);
            if (i == 8) chk("sat_reach", 32'(stall_cycles), 32'hF);
        end
        @(negedge clk);
        stallreq_ex = 1'b0;
        #1;
        chk("sat_cycles", 32'(stall_cycles), 32'hF);
        chk("sat_timeout", 32'(stall_timeout), 32'(TO_EN));

        // reset while a stall request is pending: outputs drop at once
        @(negedge clk);
        stallreq_id = 1'b1;
        rst = 1'b1;
        #1;
        chk("rst2_stall", 32'(stall), 32'h0);
        chk("rst2_cycles", 32'(stall_cycles), 32'h0);
        chk("rst2_timeout", 32'(stall_timeout), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        stallreq_id = 1'b0;

        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            stallreq_id = 1'b1;
            #1;
            chk($sformatf("run1_c%0d_timeout", k), 32'(stall_timeout), 32'h0);
        end
        @(negedge clk);
        stallreq_id = 1'b0;
        #1;
        chk("gap_timeout", 32'(stall_timeout), 32'h0);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            stallreq_id = 1'b1;
            #1;
            chk($sformatf("run2_c%0d_timeout", k), 32'(stall_timeout), 32'(TO_EN && (k == 8)));
        end
        @(negedge clk);
        stallreq_id = 1'b0;
        flush_req = 1'b1;
        flush_pc = 32'h80;
        #1;
        chk("after_run_timeout", 32'(stall_timeout), 32'(TO_EN));
        @(negedge clk);
        flush_req = 1'b0;
        stallreq_mem = 1'b1;
        #1;
        chk("mid_flush", 32'(flush), 32'h1);
        chk("mid_new_pc", new_pc, 32'h80);
        chk("mid_stall", 32'(stall), 32'h0);
        #2 rst = 1'b1;
        #1;
        chk("rst3_flush", 32'(flush), 32'h0);
        chk("rst3_new_pc", new_pc, 32'h0);
        chk("rst3_stall", 32'(stall), 32'h0);
        chk("rst3_cycles", 32'(stall_cycles), 32'h0);
        chk("rst3_timeout", 32'(stall_timeout), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        stallreq_mem = 1'b0;
        @(negedge clk);
        #1;
        chk("post_rst_flush", 32'(flush), 32'h0);
        chk("post_rst_stall", 32'(stall), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
